// File: rtl/alu_pkg.sv
// alu_pkg: ALU command encodings and datapath width shared by alu, alu_arbiter and benches.
package alu_pkg;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_LSL = 3'b001,
    ALU_SUB = 3'b110,
    ALU_CMP = 3'b111
  } alu_cmd_t;

  localparam int ALU_W = 8;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin grant over N_REQ valid lines, scanning upward from rr_ptr.
// The pointer moves to one past the winner on every accept and holds otherwise.
module rr_arbiter #(
  parameter int N_REQ = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [N_REQ-1:0]           valid,
  output logic [N_REQ-1:0]           grant,
  output logic [$clog2(N_REQ)-1:0]   grant_idx,
  output logic                       accept
);

  localparam int IW = $clog2(N_REQ);

  logic [IW-1:0] rr_ptr;
  logic          found;
  logic [IW-1:0] cand;

  always_comb begin
    found     = 1'b0;
    cand      = '0;
    grant_idx = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = (int'(rr_ptr) + k >= N_REQ) ? IW'(int'(rr_ptr) + k - N_REQ)
                                         : IW'(int'(rr_ptr) + k);
      if (!found && valid[cand]) begin
        found     = 1'b1;
        grant_idx = cand;
      end
    end
  end

  assign grant  = found ? (N_REQ'(1) << grant_idx) : '0;
  assign accept = found;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr <= '0;
    end else if (found) begin
      rr_ptr <= (grant_idx == IW'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one ALU between N_REQ requesters with a 2-stage op/response pipeline.
// Optional ALU_ARB_LOCK_EN adds req_lock so a requester can hold the ALU across accepts.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int W     = ALU_W
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_REQ-1:0]        req_valid,
`ifdef ALU_ARB_LOCK_EN
  input  logic [N_REQ-1:0]        req_lock,
`endif
  output logic [N_REQ-1:0]        req_ready,
  input  logic [N_REQ-1:0][2:0]   req_cmd,
  input  logic [N_REQ-1:0][W-1:0] req_a,
  input  logic [N_REQ-1:0][W-1:0] req_b,
  output logic [N_REQ-1:0]        rsp_valid,
  output logic [W-1:0]            rsp_rslt,
  output logic                    rsp_flag,
  output logic [2:0]              alu_cmd,
  output logic [W-1:0]            alu_a,
  output logic [W-1:0]            alu_b,
  input  logic [W-1:0]            alu_rslt,
  input  logic                    alu_flag
);

  localparam int IW = $clog2(N_REQ);

  logic [N_REQ-1:0] elig;
  logic [N_REQ-1:0] grant;
  logic [IW-1:0]    grant_idx;
  logic             accept;

  logic             op_vld;
  logic [2:0]       op_cmd;
  logic [W-1:0]     op_a;
  logic [W-1:0]     op_b;
  logic [IW-1:0]    op_owner;

`ifdef ALU_ARB_LOCK_EN
  logic          lock_vld;
  logic [IW-1:0] lock_own;

  // While locked, everyone but the lock owner is masked, even if the owner is idle.
  always_comb begin
    elig = reset ? '0 : req_valid;
    if (lock_vld) begin
      elig = elig & (N_REQ'(1) << lock_own);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lock_vld <= 1'b0;
      lock_own <= '0;
    end else if (accept) begin
      lock_vld <= req_lock[grant_idx];
      lock_own <= grant_idx;
    end else if (lock_vld && !req_valid[lock_own]) begin
      lock_vld <= 1'b0;
    end
  end
`else
  assign elig = reset ? '0 : req_valid;
`endif

  rr_arbiter #(.N_REQ(N_REQ)) u_rr_arbiter (
    .clk       (clk),
    .reset     (reset),
    .valid     (elig),
    .grant     (grant),
    .grant_idx (grant_idx),
    .accept    (accept)
  );

  assign req_ready = grant;

  assign alu_cmd = op_cmd;
  assign alu_a   = op_a;
  assign alu_b   = op_b;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_vld    <= 1'b0;
      op_cmd    <= ALU_ADD;
      op_a      <= '0;
      op_b      <= '0;
      op_owner  <= '0;
      rsp_valid <= '0;
      rsp_rslt  <= '0;
      rsp_flag  <= 1'b0;
    end else begin
      op_vld <= accept;
      if (accept) begin
        op_cmd   <= req_cmd[grant_idx];
        op_a     <= req_a[grant_idx];
        op_b     <= req_b[grant_idx];
        op_owner <= grant_idx;
      end
      // Responses cannot be stalled: one-cycle pulse to the owner of the op in the ALU.
      rsp_valid <= op_vld ? (N_REQ'(1) << op_owner) : '0;
      if (op_vld) begin
        rsp_rslt <= alu_rslt;
        rsp_flag <= alu_flag;
      end
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: table-driven check of alu_arbiter with a behavioural ALU model on the alu_* ports.
// Lock sequence is compiled only when ALU_ARB_LOCK_EN is defined.
module tb_alu_arbiter;
  import alu_pkg::*;

  localparam int N = 2;
  localparam int W = ALU_W;

  logic                clk = 1'b0;
  logic                reset;
  logic [N-1:0]        req_valid;
  logic [N-1:0]        req_ready;
  logic [N-1:0][2:0]   req_cmd;
  logic [N-1:0][W-1:0] req_a;
  logic [N-1:0][W-1:0] req_b;
  logic [N-1:0]        rsp_valid;
  logic [W-1:0]        rsp_rslt;
  logic                rsp_flag;
  logic [2:0]          alu_cmd;
  logic [W-1:0]        alu_a;
  logic [W-1:0]        alu_b;
  logic [W-1:0]        alu_rslt;
  logic                alu_flag;
`ifdef ALU_ARB_LOCK_EN
  logic [N-1:0]        req_lock;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.N_REQ(N), .W(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
`ifdef ALU_ARB_LOCK_EN
    .req_lock  (req_lock),
`endif
    .req_ready (req_ready),
    .req_cmd   (req_cmd),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_rslt  (rsp_rslt),
    .rsp_flag  (rsp_flag),
    .alu_cmd   (alu_cmd),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_rslt  (alu_rslt),
    .alu_flag  (alu_flag)
  );

  // Behavioural ALU: ADD carry, LSL last bit out, SUB borrow, CMP equality, others pass A.
  logic [W:0] wide;
  always_comb begin
    wide     = '0;
    alu_flag = 1'b0;
    case (alu_cmd)
      3'b000: begin wide = {1'b0, alu_a} + {1'b0, alu_b}; alu_flag = wide[W]; end
      3'b001: begin wide = {1'b0, alu_a} << alu_b[2:0];   alu_flag = wide[W]; end
      3'b110: begin wide = {1'b0, alu_a - alu_b}; alu_flag = (alu_a < alu_b);  end
      3'b111: begin wide = {1'b0, alu_a - alu_b}; alu_flag = (alu_a == alu_b); end
      default: wide = {1'b0, alu_a};
    endcase
    alu_rslt = wide[W-1:0];
  end

  typedef struct {
    logic [N-1:0] valid;
    logic [2:0]   cmd0;
    logic [W-1:0] a0;
    logic [W-1:0] b0;
    logic [2:0]   cmd1;
    logic [W-1:0] a1;
    logic [W-1:0] b1;
    logic [N-1:0] ready;
    logic [N-1:0] rsp;
    logic [W-1:0] rslt;
    logic         flag;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(int valid, int cmd0, int a0, int b0, int cmd1, int a1, int b1,
                              int ready, int rsp, int rslt, int flag);
    vec_t v;
    v.valid = N'(valid);
    v.cmd0  = 3'(cmd0);
    v.a0    = W'(a0);
    v.b0    = W'(b0);
    v.cmd1  = 3'(cmd1);
    v.a1    = W'(a1);
    v.b1    = W'(b1);
    v.ready = N'(ready);
    v.rsp   = N'(rsp);
    v.rslt  = W'(rslt);
    v.flag  = 1'(flag);
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    req_valid  = v.valid;
    req_cmd[0] = v.cmd0;
    req_a[0]   = v.a0;
    req_b[0]   = v.b0;
    req_cmd[1] = v.cmd1;
    req_a[1]   = v.a1;
    req_b[1]   = v.b1;
  endtask

  task automatic drive(input int valid, input int cmd0, input int a0, input int b0);
    req_valid  = N'(valid);
    req_cmd[0] = 3'(cmd0);
    req_a[0]   = W'(a0);
    req_b[0]   = W'(b0);
    req_cmd[1] = 3'b000;
    req_a[1]   = '0;
    req_b[1]   = '0;
  endtask

  initial begin
    // columns: valid, cmd0,a0,b0, cmd1,a1,b1, ready, rsp_valid, rsp_rslt, rsp_flag
    vecs.push_back(mk(3, 6, 3, 6,      7, 4, 4,     1, 0, 0,   0));
    vecs.push_back(mk(2, 0, 0, 0,      7, 4, 4,     2, 0, 0,   0));
    vecs.push_back(mk(0, 0, 0, 0,      0, 0, 0,     0, 1, 253, 1));
    vecs.push_back(mk(1, 0, 5, 6,      0, 0, 0,     1, 2, 0,   1));
    vecs.push_back(mk(0, 0, 0, 0,      0, 0, 0,     0, 0, 0,   1));
    vecs.push_back(mk(0, 0, 0, 0,      0, 0, 0,     0, 1, 11,  0));
    for (int k = 0; k < 8; k++) begin
      vecs.push_back(mk(3, 1, 'h80, 1, 1, 'h80, 1, (k % 2 == 0) ? 2 : 1,
                        (k < 2) ? 0 : ((k % 2 == 0) ? 2 : 1),
                        (k < 2) ? 11 : 0, (k < 2) ? 0 : 1));
    end
    vecs.push_back(mk(0, 0, 0, 0,      0, 0, 0,     0, 2, 0,    1));
    vecs.push_back(mk(0, 0, 0, 0,      0, 0, 0,     0, 1, 0,    1));
    vecs.push_back(mk(2, 0, 0, 0,      3, 'h5A, 'h11, 2, 0, 0,  1));
    vecs.push_back(mk(0, 0, 0, 0,      0, 0, 0,     0, 0, 0,    1));
    vecs.push_back(mk(0, 0, 0, 0,      0, 0, 0,     0, 2, 'h5A, 0));
    vecs.push_back(mk(1, 0, 200, 100,  0, 0, 0,     1, 0, 'h5A, 0));
    vecs.push_back(mk(1, 1, 'h81, 1,   0, 0, 0,     1, 0, 'h5A, 0));
    vecs.push_back(mk(1, 6, 6, 3,      0, 0, 0,     1, 1, 44,   1));
    vecs.push_back(mk(0, 0, 0, 0,      0, 0, 0,     0, 1, 2,    1));
    vecs.push_back(mk(0, 0, 0, 0,      0, 0, 0,     0, 1, 3,    0));
    vecs.push_back(mk(0, 0, 0, 0,      0, 0, 0,     0, 0, 3,    0));

    // Reset state with requests already pending: nothing may be granted.
    reset = 1'b1;
`ifdef ALU_ARB_LOCK_EN
    req_lock = '0;
`endif
    drive(3, 0, 9, 9);
    #12;
    checkOutput("reset req_ready", 32'(req_ready), 32'd0);
    checkOutput("reset rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("reset rsp_rslt",  32'(rsp_rslt),  32'd0);
    checkOutput("reset rsp_flag",  32'(rsp_flag),  32'd0);
    checkOutput("reset alu_cmd",   32'(alu_cmd),   32'd0);
    checkOutput("reset alu_a",     32'(alu_a),     32'd0);
    checkOutput("reset alu_b",     32'(alu_b),     32'd0);
    drive(0, 0, 0, 0);
    @(posedge clk); #1;
    reset = 1'b0;

    foreach (vecs[i]) begin
      @(posedge clk); #1;
      applyStimulus(vecs[i]);
      @(negedge clk);
      checkOutput($sformatf("row%0d req_ready", i), 32'(req_ready), 32'(vecs[i].ready));
      checkOutput($sformatf("row%0d rsp_valid", i), 32'(rsp_valid), 32'(vecs[i].rsp));
      checkOutput($sformatf("row%0d rsp_rslt", i),  32'(rsp_rslt),  32'(vecs[i].rslt));
      checkOutput($sformatf("row%0d rsp_flag", i),  32'(rsp_flag),  32'(vecs[i].flag));
    end

    // Reset in the middle of an in-flight ADD 0,20: its response must never appear.
    @(posedge clk); #1;
    drive(1, 0, 0, 20);
    @(negedge clk);
    checkOutput("midop accept ready", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    drive(0, 0, 0, 0);
    checkOutput("midop alu_b issued", 32'(alu_b), 32'd20);
    checkOutput("midop alu_cmd issued", 32'(alu_cmd), 32'd0);
    #2;
    reset = 1'b1;
    drive(3, 0, 1, 1);
    #1;
    checkOutput("async reset alu_b",     32'(alu_b),     32'd0);
    checkOutput("async reset req_ready", 32'(req_ready), 32'd0);
    checkOutput("async reset rsp_rslt",  32'(rsp_rslt),  32'd0);
    checkOutput("async reset rsp_valid", 32'(rsp_valid), 32'd0);
    @(posedge clk); #1;
    drive(0, 0, 0, 0);
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checkOutput($sformatf("midop no rsp %0d", k), 32'(rsp_valid), 32'd0);
    end
    @(posedge clk); #1;
    drive(3, 0, 1, 2);
    @(negedge clk);
    checkOutput("post reset first grant", 32'(req_ready), 32'd1);

`ifdef ALU_ARB_LOCK_EN
    // req0 accepted above, pointer now at 1; req1 takes the lock while req0 waits.
    @(posedge clk); #1;
    drive(3, 0, 1, 2);
    req_lock = 2'b10;
    @(negedge clk);
    checkOutput("lock take", 32'(req_ready), 32'd2);
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("lock hold blocks req0", 32'(req_ready), 32'd2);
    @(posedge clk); #1;
    req_lock = 2'b00;
    @(negedge clk);
    checkOutput("lock release op", 32'(req_ready), 32'd2);
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("req0 after release", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_lock = 2'b10;
    @(negedge clk);
    checkOutput("relock take", 32'(req_ready), 32'd2);
    @(posedge clk); #1;
    drive(1, 0, 1, 2);
    req_lock = 2'b00;
    @(negedge clk);
    checkOutput("lock owner idle blocks req0", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("lock dropped by idle owner", 32'(req_ready), 32'd1);
`endif

    @(posedge clk); #1;
    drive(0, 0, 0, 0);
    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
